// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg
// Shared types for the start-pulse meter family.
//   spm_state_t : measurement FSM states
//   spm_rec_t   : length record {timeout, len} at the default counter width;
//                 meters with another CNT_W pack their own {timeout, len}
//                 vector of width CNT_W+1 in the same bit order.
// -----------------------------------------------------------------------------
package spm_pkg;

    localparam int unsigned SPM_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } spm_state_t;

    typedef struct packed {
        logic                 timeout;
        logic [SPM_CNT_W-1:0] len;
    } spm_rec_t;

endpackage

// File: rtl/spm_out_reg.sv
// -----------------------------------------------------------------------------
// spm_out_reg
// Single-entry valid/ready holding register with drop indication.
// A load while the register is full and not being drained is discarded and
// flagged on drop for one cycle; a load in the same cycle as a drain replaces
// the record back-to-back.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : a new record is offered this cycle
//   load_data   : the offered record
//   ready       : consumer accepts the held record this cycle
//   valid       : a record is held in data
//   data        : held record (zero when empty)
//   drop        : one-cycle pulse, an offered record was discarded
// -----------------------------------------------------------------------------
module spm_out_reg
    import spm_pkg::*;
#(
    parameter int unsigned DATA_W = SPM_CNT_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              drop
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic              drop_r;
    logic              accept_s;

    // The register can take a new record when empty or being drained now.
    assign accept_s = load & (~valid_r | ready);

    // Holding register: load, drain or hold; drop flags a discarded load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            drop_r  <= 1'b0;
        end else begin
            drop_r <= load & valid_r & ~ready;
            if (accept_s) begin
                valid_r <= 1'b1;
                data_r  <= load_data;
            end else if (valid_r & ready) begin
                valid_r <= 1'b0;
                data_r  <= {DATA_W{1'b0}};
            end else begin
                valid_r <= valid_r;
                data_r  <= data_r;
            end
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign drop  = drop_r;

endmodule

// File: rtl/start_pulse_meter.sv
// -----------------------------------------------------------------------------
// start_pulse_meter
// Measures how many consecutive clock samples `start` stays high after a
// rising edge and emits a {timeout, len} record on the terminating sample.
// Pulses longer than MAX_LEN emit {MAX_LEN, timeout=1} on the (MAX_LEN+1)th
// high sample; the rest of such a pulse is ignored.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : strobe under measurement
//   out_ready    : consumer accepts the record this cycle
//   out_valid    : record held in out_len/out_timeout
//   out_len      : number of high samples in the pulse
//   out_timeout  : pulse exceeded MAX_LEN (out_len == MAX_LEN)
//   drop         : one-cycle pulse, a record was lost to a full register
//   busy         : FSM is not idle
// -----------------------------------------------------------------------------
module start_pulse_meter
    import spm_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MAX_LEN = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_len,
    output logic             out_timeout,
    output logic             drop,
    output logic             busy
);

    if ((MAX_LEN < 1) || (MAX_LEN > ((2 ** CNT_W) - 1))) begin : g_bad_max_len
        $error("start_pulse_meter: MAX_LEN out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    spm_state_t       state_r;
    spm_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             start_q_r;
    logic             busy_r;
    logic             rise_s;
    logic             emit_s;
    logic [CNT_W-1:0] emit_len_s;
    logic             emit_timeout_s;
    logic [CNT_W:0]   emit_rec_s;
    logic [CNT_W:0]   out_rec_s;

    // start_q resets high so a pulse already in flight at release is ignored.
    assign rise_s = start & ~start_q_r;

    // State, counter, previous-sample and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= ZERO_CNT;
            start_q_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            start_q_r <= start;
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = MEASURE;
                    cnt_nxt_s   = ONE_CNT;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = ZERO_CNT;
                end
            end
            MEASURE: begin
                if (start) begin
                    if (cnt_r == MAX_CNT) begin
                        state_nxt_s = STUCK;
                        cnt_nxt_s   = ZERO_CNT;
                    end else begin
                        state_nxt_s = MEASURE;
                        cnt_nxt_s   = cnt_r + ONE_CNT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = ZERO_CNT;
                end
            end
            STUCK: begin
                // Only a low sample releases STUCK; rises are taken from IDLE.
                if (!start) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STUCK;
                end
                cnt_nxt_s = ZERO_CNT;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = ZERO_CNT;
            end
        endcase
    end

    // Record emission: a timeout on the (MAX_LEN+1)th high sample, or the
    // measured length on the first low sample.
    always_comb begin
        emit_s         = 1'b0;
        emit_len_s     = ZERO_CNT;
        emit_timeout_s = 1'b0;
        case (state_r)
            MEASURE: begin
                if (start) begin
                    if (cnt_r == MAX_CNT) begin
                        emit_s         = 1'b1;
                        emit_len_s     = MAX_CNT;
                        emit_timeout_s = 1'b1;
                    end else begin
                        emit_s         = 1'b0;
                        emit_len_s     = ZERO_CNT;
                        emit_timeout_s = 1'b0;
                    end
                end else begin
                    emit_s         = 1'b1;
                    emit_len_s     = cnt_r;
                    emit_timeout_s = 1'b0;
                end
            end
            IDLE, STUCK: begin
                emit_s         = 1'b0;
                emit_len_s     = ZERO_CNT;
                emit_timeout_s = 1'b0;
            end
            default: begin
                emit_s         = 1'b0;
                emit_len_s     = ZERO_CNT;
                emit_timeout_s = 1'b0;
            end
        endcase
    end

    // Same bit order as spm_rec_t: timeout above len.
    assign emit_rec_s = {emit_timeout_s, emit_len_s};

    spm_out_reg #(
        .DATA_W (CNT_W + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (emit_s),
        .load_data (emit_rec_s),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_rec_s),
        .drop      (drop)
    );

    assign out_len     = out_rec_s[CNT_W-1:0];
    assign out_timeout = out_rec_s[CNT_W];
    assign busy        = busy_r;

endmodule

// File: tb/tb_start_pulse_meter.sv
// -----------------------------------------------------------------------------
// tb_start_pulse_meter
// Directed bench for start_pulse_meter. Inputs change on the falling clock
// edge, outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_start_pulse_meter;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned MAX_LEN = 14;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [CNT_W-1:0] out_len;
    logic             out_timeout;
    logic             drop;
    logic             busy;

    int n_checks;
    int n_pass;

    start_pulse_meter #(
        .CNT_W   (CNT_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_len     (out_len),
        .out_timeout (out_timeout),
        .drop        (drop),
        .busy        (busy)
    );

    // Period 10, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish before t=100000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input int len,
                             input logic to, input logic dr);
        check({tag, ".valid"},   32'(out_valid),   32'(v));
        check({tag, ".len"},     32'(out_len),     32'(len));
        check({tag, ".timeout"}, 32'(out_timeout), 32'(to));
        check({tag, ".drop"},    32'(drop),        32'(dr));
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Drive start high from the next falling edge for n rising edges.
    task automatic high(input int n);
        @(negedge clk);
        start = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop start (and set out_ready) on the next falling edge, then sample
    // just after the rising edge that sees the low sample.
    task automatic low(input logic rdy);
        @(negedge clk);
        start     = 1'b0;
        out_ready = rdy;
        sample();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #6;
        check_out("reset", 1'b0, 0, 1'b0, 1'b0);
        check("reset.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: start high t=20..80, six samples
        high(6);
        check("t1.busy_in", 32'(busy), 32'd1);
        check("t1.valid_in", 32'(out_valid), 32'd0);
        low(1'b1);
        check_out("t1.emit", 1'b1, 6, 1'b0, 1'b0);
        check("t1.busy_end", 32'(busy), 32'd0);
        sample();
        check("t1.clear", 32'(out_valid), 32'd0);

        // 2: exactly MAX_LEN, then a 20-sample pulse
        high(14);
        low(1'b1);
        check_out("t2.max", 1'b1, 14, 1'b0, 1'b0);
        high(14);
        check("t2.pre_to.valid", 32'(out_valid), 32'd0);
        check("t2.pre_to.busy", 32'(busy), 32'd1);
        sample();
        check_out("t2.to", 1'b1, 14, 1'b1, 1'b0);
        check("t2.to.busy", 32'(busy), 32'd1);
        repeat (5) sample();
        check("t2.stuck.busy", 32'(busy), 32'd1);
        check("t2.stuck.valid", 32'(out_valid), 32'd0);
        low(1'b1);
        check("t2.fall.valid", 32'(out_valid), 32'd0);
        check("t2.fall.busy", 32'(busy), 32'd0);

        // 3: one-sample pulse, one low sample, three-sample pulse
        high(1);
        low(1'b1);
        check_out("t3.one", 1'b1, 1, 1'b0, 1'b0);
        high(3);
        check_out("t3.gap", 1'b0, 0, 1'b0, 1'b0);
        low(1'b1);
        check_out("t3.three", 1'b1, 3, 1'b0, 1'b0);
        sample();

        // 4: consumer stalled across two pulses
        high(4);
        low(1'b0);
        check_out("t4.first", 1'b1, 4, 1'b0, 1'b0);
        sample();
        check_out("t4.hold", 1'b1, 4, 1'b0, 1'b0);
        high(2);
        low(1'b0);
        check_out("t4.drop", 1'b1, 4, 1'b0, 1'b1);
        sample();
        check_out("t4.after", 1'b1, 4, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        sample();
        check_out("t4.drain", 1'b0, 0, 1'b0, 1'b0);

        // 5: drain coincides with a new emit
        @(negedge clk);
        out_ready = 1'b0;
        high(3);
        low(1'b0);
        check_out("t5.held", 1'b1, 3, 1'b0, 1'b0);
        high(5);
        check_out("t5.still", 1'b1, 3, 1'b0, 1'b0);
        low(1'b1);
        check_out("t5.b2b", 1'b1, 5, 1'b0, 1'b0);
        sample();
        check_out("t5.clear", 1'b0, 0, 1'b0, 1'b0);

        // 6: reset mid-pulse with a record held
        @(negedge clk);
        out_ready = 1'b0;
        high(2);
        low(1'b0);
        check_out("t6.held", 1'b1, 2, 1'b0, 1'b0);
        high(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out("t6.rst", 1'b0, 0, 1'b0, 1'b0);
        check("t6.rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) sample();
        check("t6.ignored.busy", 32'(busy), 32'd0);
        low(1'b1);
        check_out("t6.fall", 1'b0, 0, 1'b0, 1'b0);
        check("t6.fall.busy", 32'(busy), 32'd0);
        high(3);
        low(1'b1);
        check_out("t6.clean", 1'b1, 3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/start_pulse_meter.md
Name: start_pulse_meter

Overview:
Downstream consumer of the testbench-level `start` strobe. It measures how many consecutive clock samples `start` stays high after a rising edge. On the falling edge it emits a length record through a single-entry valid/ready output register. Pulses longer than MAX_LEN are flagged as timeouts, which is the RTL counterpart of a bounded `start[*1:MAX_LEN] ##1 !start` check. The block sits between the start generator and the stats/scoreboard logic.

Parameters:
CNT_W, 8, width of the length counter and of out_len.
MAX_LEN, 14, longest legal pulse in high samples; legal range 1 .. 2**CNT_W-1 (elaboration-time check).

Ports:
clk  input  1  single clock; all sampling on posedge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  strobe under measurement; synchronous to clk.
out_ready  input  1  consumer accepts the record this cycle.
out_valid  output  1  record held in out_len/out_timeout.
out_len  output  CNT_W  number of high samples in the pulse.
out_timeout  output  1  pulse exceeded MAX_LEN; out_len then equals MAX_LEN.
drop  output  1  one-cycle pulse: a record was lost because the output register was full.
busy  output  1  high while state != IDLE.

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, cnt=0, start_q=1, out_valid=0, out_len=0, out_timeout=0, drop=0.
  - Because start_q resets to 1, a pulse already high at reset release is ignored until `start` is seen low.
- start_q holds the previous sample of `start`.
  - rise = start & !start_q.
  - fall = !start & start_q.
- States:
  - IDLE: on rise → cnt<=1, go MEASURE.
  - MEASURE, `start` high:
    - if cnt==MAX_LEN → emit {len=MAX_LEN, timeout=1}, go STUCK.
    - else cnt<=cnt+1.
  - MEASURE, `start` low (fall) → emit {len=cnt, timeout=0}, go IDLE.
  - STUCK: wait for `start` low, then go IDLE. No second record is emitted. A rise is only accepted from IDLE, so the minimum gap between pulses is one low sample.
- Emit semantics:
  - The record is loaded on the same edge that samples the terminating condition. out_valid is visible from that edge on.
  - Latency: zero cycles after the low sample; for a timeout, zero cycles after the (MAX_LEN+1)th high sample.
- Output handshake:
  - The record holds stable while out_valid & !out_ready.
  - It is cleared on out_valid & out_ready when no emit happens in the same cycle.
- Emit while out_valid & !out_ready:
  - The held record is kept and the new one is discarded.
  - drop=1 for exactly that cycle.
- Emit while out_valid & out_ready: the new record loads, out_valid stays 1, and there is no drop.
- Emit while !out_valid: the record loads.
- cnt never exceeds MAX_LEN, so no wrap-around is possible.
- Single-sample pulse → len=1.
- Reset mid-pulse aborts the measurement and discards any held record. After release the in-flight pulse is ignored because start_q=1.

Decomposition:
- Package spm_pkg:
  - typedef enum logic [1:0] {IDLE, MEASURE, STUCK} spm_state_t;
  - typedef struct packed {logic timeout; logic [CNT_W-1:0] len;} spm_rec_t. The struct is parameterised via a localparam default of 8; the module casts to its own CNT_W.
- One sub-module, spm_out_reg: a single-entry valid/ready holding register with drop indication. It is reusable by sibling meters.
- The FSM and counter stay in the top module.

Test Plan:
1. `start` rises at t=20 and falls at t=80 (clk period 10, first posedge t=5), out_ready=1 → high samples at 25..75; out_valid at the t=85 edge with out_len=6, out_timeout=0; cleared next edge.
2. Pulse of exactly 14 high samples, then a pulse of 20 → first record {14,0}; second record {14,1} loaded at the 15th high sample; no further record when `start` falls; busy is held through STUCK.
3. One-sample pulse, low one sample, then a 3-sample pulse, out_ready=1 → records {1,0} then {3,0}; drop never asserts.
4. out_ready=0 while two pulses (len 4, then 2) complete → out_len stays 4; drop=1 for one cycle at the second emit; raising out_ready then yields out_valid=0 the next cycle.
5. out_ready=1 exactly on the cycle a new record emits while one is held → new record loaded back-to-back, out_valid continuous, drop=0.
6. Assert rst_n=0 mid-pulse (cnt=5), release while `start` is still high → all outputs 0; no record for that pulse; next clean pulse of 3 gives {3,0}.
